// File: rtl/mem_pkg.sv
// Shared definitions for the pipelined word memory: FSM encoding, fill modes and the ISA NOP word.
package mem_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } memState_t;

  // Fill value used when the memory serves as instruction memory.
  localparam logic [15:0] NOP_WORD = 16'h7000;

  // Init sweep fill modes.
  localparam int INIT_IDENTITY = 0;  // mem[i] = i
  localparam int INIT_FILL     = 1;  // mem[i] = INIT_WORD

endpackage

// File: rtl/pipelined_word_memory_if.sv
// Request/response and init-control bundle of the pipelined word memory.
interface pipelined_word_memory_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              init_req;
  logic              init_busy;
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;

  // Requester side (core or testbench).
  modport master (
    output init_req, req_valid, req_write, req_addr, req_wdata,
    input  init_busy, req_ready, rsp_valid, rsp_rdata
  );

  // Memory side.
  modport slave (
    input  init_req, req_valid, req_write, req_addr, req_wdata,
    output init_busy, req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_rd_pipe.sv
// Read-response delay line: LAT stages of valid+data. Data of a stage only moves when the stage
// before it is valid, so the output word holds until the next response arrives.
module mem_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int LAT    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inValid,
  input  logic [DATA_W-1:0] inData,
  output logic              outValid,
  output logic [DATA_W-1:0] outData
);

  logic [LAT-1:0]    vPipe;
  logic [DATA_W-1:0] dPipe [LAT];

  // Shift valid every cycle; advance data only behind a valid so the last word is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vPipe <= '0;
      for (int i = 0; i < LAT; i++) dPipe[i] <= '0;
    end else begin
      vPipe[0] <= inValid;
      if (inValid) dPipe[0] <= inData;
      for (int i = 1; i < LAT; i++) begin
        vPipe[i] <= vPipe[i-1];
        if (vPipe[i-1]) dPipe[i] <= dPipe[i-1];
      end
    end
  end

  assign outValid = vPipe[LAT-1];
  assign outData  = dPipe[LAT-1];

endmodule

// File: rtl/pipelined_word_memory.sv
// Synchronous word memory with a valid/ready request port, READ_LAT-cycle read responses and a
// sequential init sweep (identity or fill) that runs after reset and on every init_req pulse.
module pipelined_word_memory
  import mem_pkg::*;
#(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 16,
  parameter int              DEPTH_LOG2 = 12,
  parameter int              READ_LAT   = 1,
  parameter int              INIT_MODE  = INIT_IDENTITY,
  parameter logic [DATA_W-1:0] INIT_WORD = DATA_W'(NOP_WORD)
) (
  input logic                     clk,
  input logic                     reset,
  pipelined_word_memory_if.slave  bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  if (READ_LAT != 1 && READ_LAT != 2) begin : gBadReadLat
    $error("pipelined_word_memory: READ_LAT must be 1 or 2");
  end

  memState_t             stateQ, stateD;
  logic [DEPTH_LOG2-1:0] initCnt;
  logic [DATA_W-1:0]     mem [DEPTH];

  logic [DEPTH_LOG2-1:0] reqIdx;
  logic                  running;
  logic                  wrFire, rdFire;
  logic                  memWe;
  logic [DEPTH_LOG2-1:0] memIdx;
  logic [DATA_W-1:0]     memWdata;
  logic [DATA_W-1:0]     initVal;
  logic [DATA_W-1:0]     rdData;
  logic                  unusedAddrHigh;

  // Upper address bits alias onto the same words.
  assign reqIdx         = bus.req_addr[DEPTH_LOG2-1:0];
  assign unusedAddrHigh = ^bus.req_addr;

  assign running = (stateQ == ST_RUN);
  assign wrFire  = running & bus.req_valid & bus.req_write;
  assign rdFire  = running & bus.req_valid & ~bus.req_write;

  assign initVal = (INIT_MODE == INIT_FILL) ? INIT_WORD : DATA_W'(initCnt);

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) stateQ <= ST_INIT;
    else        stateQ <= stateD;
  end

  // Init sweep counter: counts in INIT, restarts from 0 when a new sweep is requested.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     initCnt <= '0;
    else if (stateQ == ST_INIT)     initCnt <= initCnt + 1'b1;
    else if (bus.init_req)          initCnt <= '0;
  end

  // Next state: leave INIT after the last word is written; init_req re-enters it from RUN.
  // NOTE: default every always_comb output first so no path can infer a latch.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_INIT: if (initCnt == '1)  stateD = ST_RUN;
      ST_RUN:  if (bus.init_req)   stateD = ST_INIT;
      default:                     stateD = ST_INIT;
    endcase
  end

  // Outputs decoded from state: ready only in RUN, busy during the sweep.
  always_comb begin
    bus.req_ready = (stateQ == ST_RUN);
    bus.init_busy = (stateQ == ST_INIT);
  end

  // Write port mux: the sweep owns the array in INIT, accepted writes own it in RUN.
  always_comb begin
    memWe    = 1'b0;
    memIdx   = reqIdx;
    memWdata = bus.req_wdata;
    if (stateQ == ST_INIT) begin
      memWe    = 1'b1;
      memIdx   = initCnt;
      memWdata = initVal;
    end else if (wrFire) begin
      memWe    = 1'b1;
    end
  end

  // Array write.
  // NOTE: the array has no reset; its contents are defined by the init sweep instead.
  always_ff @(posedge clk) begin
    if (memWe) mem[memIdx] <= memWdata;
  end

  // The read word is captured at the accept edge by the first pipe stage.
  assign rdData = mem[reqIdx];

  mem_rd_pipe #(
    .DATA_W (DATA_W),
    .LAT    (READ_LAT)
  ) uRdPipe (
    .clk      (clk),
    .reset    (reset),
    .inValid  (rdFire),
    .inData   (rdData),
    .outValid (bus.rsp_valid),
    .outData  (bus.rsp_rdata)
  );

endmodule

// File: tb/tb_pipelined_word_memory.sv
// Directed bench: dut0 = identity fill, READ_LAT=1; dut1 = NOP fill, READ_LAT=2.
module tb_pipelined_word_memory;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   n;

  always #5 clk = ~clk;

  pipelined_word_memory_if #(.DATA_W(16), .ADDR_W(16)) bus0 ();
  pipelined_word_memory_if #(.DATA_W(16), .ADDR_W(16)) bus1 ();

  pipelined_word_memory #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .READ_LAT(1),
    .INIT_MODE(INIT_IDENTITY), .INIT_WORD(16'h7000)
  ) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  pipelined_word_memory #(
    .DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .READ_LAT(2),
    .INIT_MODE(INIT_FILL), .INIT_WORD(16'h7000)
  ) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single write on dut0; called just after a posedge, returns just after the accept edge.
  task automatic wr0(input logic [15:0] a, input logic [15:0] d);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.req_addr  = a;
    bus0.req_wdata = d;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus0.req_write = 1'b0;
  endtask

  // Single read on dut0 (latency 1): response is visible right after the accept edge.
  task automatic rd0(input logic [15:0] a, input logic [15:0] exp, input string tag);
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b0;
    bus0.req_addr  = a;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    check({tag, "_valid"}, bus0.rsp_valid, 1);
    check({tag, "_data"},  bus0.rsp_rdata, exp);
  endtask

  // Counts posedges while dut0 reports init_busy, bounded.
  task automatic measureInit(input string tag);
    int cnt = 0;
    while (bus0.init_busy === 1'b1 && cnt < 5000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check(tag, cnt, 4096);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus0.init_req = 1'b0; bus0.req_valid = 1'b0; bus0.req_write = 1'b0;
    bus0.req_addr = '0;   bus0.req_wdata = '0;
    bus1.init_req = 1'b0; bus1.req_valid = 1'b0; bus1.req_write = 1'b0;
    bus1.req_addr = '0;   bus1.req_wdata = '0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    check("rst_busy",      bus0.init_busy, 1);
    check("rst_ready",     bus0.req_ready, 0);
    check("rst_rsp_valid", bus0.rsp_valid, 0);
    check("rst_rsp_data",  bus0.rsp_rdata, 0);
    check("rst_busy1",     bus1.init_busy, 1);
    check("rst_rsp_data1", bus1.rsp_rdata, 0);

    // Tests 1 and 3: sweep length, requests and init_req ignored during INIT
    @(negedge clk);
    reset = 1'b1;
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b1;
    bus0.req_addr  = 16'h0003;
    bus0.req_wdata = 16'h1234;
    n = 0;
    while (bus0.init_busy === 1'b1 && n < 5000) begin
      if (n == 10) begin bus0.req_valid = 1'b0; bus0.req_write = 1'b0; end
      if (n == 20) bus0.init_req = 1'b1;
      if (n == 21) bus0.init_req = 1'b0;
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        check("t3_ready_in_init", bus0.req_ready, 0);
        check("t3_no_rsp_in_init", bus0.rsp_valid, 0);
      end
    end
    check("t1_init_len", n, 4096);
    check("t1_ready_after", bus0.req_ready, 1);
    check("t6_busy1_done", bus1.init_busy, 0);
    rd0(16'h0005, 16'h0005, "t1_rd5");
    @(posedge clk); #1;
    check("t1_single_pulse", bus0.rsp_valid, 0);
    rd0(16'h0003, 16'h0003, "t3_rd3");

    // Test 2: read-after-write, then a 16-deep back-to-back read stream
    wr0(16'h000A, 16'hBEEF);
    rd0(16'h000A, 16'hBEEF, "t2_raw");
    for (int i = 0; i < 16; i++) begin
      bus0.req_valid = 1'b1;
      bus0.req_write = 1'b0;
      bus0.req_addr  = 16'(i);
      @(posedge clk); #1;
      check($sformatf("t2_stream%0d_valid", i), bus0.rsp_valid, 1);
      check($sformatf("t2_stream%0d_data", i),  bus0.rsp_rdata,
            (i == 10) ? 32'h0000_BEEF : 32'(i));
    end
    bus0.req_valid = 1'b0;
    @(posedge clk); #1;
    check("t2_stream_end", bus0.rsp_valid, 0);
    check("t2_data_held",  bus0.rsp_rdata, 16'h000F);

    // Test 4: reset mid-RUN flushes output; reset again at counter=100 restarts the sweep
    reset = 1'b0;
    #1;
    check("t4_flush_data", bus0.rsp_rdata, 0);
    check("t4_busy_in_rst", bus0.init_busy, 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("t4_busy_at100", bus0.init_busy, 1);
    reset = 1'b0;
    #1;
    check("t4_ready_in_rst", bus0.req_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    measureInit("t4_init_len");
    rd0(16'h000A, 16'h000A, "t4_rd_a_reinit");

    // Test 5: alias write, then init_req together with an accepted read
    wr0(16'h1005, 16'hAAAA);
    rd0(16'h0005, 16'hAAAA, "t5_alias");
    bus0.req_valid = 1'b1;
    bus0.req_write = 1'b0;
    bus0.req_addr  = 16'h0005;
    bus0.init_req  = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    bus0.init_req  = 1'b0;
    check("t5_rd_with_init_valid", bus0.rsp_valid, 1);
    check("t5_rd_with_init_data",  bus0.rsp_rdata, 16'hAAAA);
    check("t5_ready_dropped",      bus0.req_ready, 0);
    measureInit("t5_init_len");
    rd0(16'h0005, 16'h0005, "t5_rd5_reinit");

    // Test 6: NOP fill with 2-cycle read latency
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b0;
    bus1.req_addr  = 16'h07FF;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    check("t6_lat_cycle1", bus1.rsp_valid, 0);
    @(posedge clk); #1;
    check("t6_lat_cycle2_valid", bus1.rsp_valid, 1);
    check("t6_lat_cycle2_data",  bus1.rsp_rdata, 16'h7000);
    @(posedge clk); #1;
    check("t6_pulse_end", bus1.rsp_valid, 0);
    check("t6_data_held", bus1.rsp_rdata, 16'h7000);
    bus1.req_valid = 1'b1;
    bus1.req_write = 1'b1;
    bus1.req_addr  = 16'h0010;
    bus1.req_wdata = 16'h5555;
    @(posedge clk); #1;
    bus1.req_write = 1'b0;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    check("t6_raw_cycle1", bus1.rsp_valid, 0);
    @(posedge clk); #1;
    check("t6_raw_valid", bus1.rsp_valid, 1);
    check("t6_raw_data",  bus1.rsp_rdata, 16'h5555);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
